// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vend_pkg
// Brief   : Shared types and constants for the change payout controller.
// Revision: 1.0 - initial release
// ============================================================================
package vend_pkg;

    localparam int AMT_W     = 8;
    localparam int N_HOPPERS = 3;
    localparam int DEN0      = 10;
    localparam int DEN1      = 5;
    localparam int DEN2      = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_PULSE    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

endpackage : vend_pkg
`default_nettype wire

// File: rtl/change_hopper_select.sv
`default_nettype none
// ============================================================================
// Module  : change_hopper_select
// Brief   : Combinational largest-denomination-first hopper picker.
// Revision: 1.0 - initial release
// ============================================================================
module change_hopper_select
    import vend_pkg::*;
#(
    parameter int AMT_W_P = AMT_W,
    parameter int DEN0_P  = DEN0,
    parameter int DEN1_P  = DEN1,
    parameter int DEN2_P  = DEN2
) (
    input  logic [AMT_W_P-1:0] remaining,
    input  logic [2:0]         hopper_empty,
    input  logic [2:0]         hopper_fault,
    output logic [1:0]         sel,
    output logic               sel_valid
);

    localparam logic [AMT_W_P-1:0] c_den0 = AMT_W_P'(DEN0_P);
    localparam logic [AMT_W_P-1:0] c_den1 = AMT_W_P'(DEN1_P);
    localparam logic [AMT_W_P-1:0] c_den2 = AMT_W_P'(DEN2_P);

    logic [2:0] w_ok;

    assign w_ok[0] = (c_den0 <= remaining) && !hopper_empty[0] && !hopper_fault[0];
    assign w_ok[1] = (c_den1 <= remaining) && !hopper_empty[1] && !hopper_fault[1];
    assign w_ok[2] = (c_den2 <= remaining) && !hopper_empty[2] && !hopper_fault[2];

    // Evaluated smallest-first so the lowest qualifying index wins.
    always_comb begin
        sel       = 2'd0;
        sel_valid = 1'b0;
        if (w_ok[2]) begin
            sel       = 2'd2;
            sel_valid = 1'b1;
        end
        if (w_ok[1]) begin
            sel       = 2'd1;
            sel_valid = 1'b1;
        end
        if (w_ok[0]) begin
            sel       = 2'd0;
            sel_valid = 1'b1;
        end
    end

endmodule : change_hopper_select
`default_nettype wire

// File: rtl/change_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : change_dispense_ctrl
// Brief   : Pays out change one coin at a time over three hoppers.
// Revision: 1.0 - initial release
// ============================================================================
module change_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int AMT_W_P     = AMT_W,
    parameter int DEN0_P      = DEN0,
    parameter int DEN1_P      = DEN1,
    parameter int DEN2_P      = DEN2,
    parameter int PULSE_LEN   = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [AMT_W_P-1:0] req_amount,
    output logic               req_ready,
    input  logic [2:0]         hopper_empty,
    input  logic               disp_ack,
    output logic [1:0]         disp_sel,
    output logic               disp_pulse,
    output logic               busy,
    output logic               done,
    output logic [AMT_W_P-1:0] shortfall,
    output logic [2:0]         hopper_fault,
    output logic [AMT_W_P-1:0] coins_out
);

    localparam int CNT_MAX = (PULSE_LEN > ACK_TIMEOUT) ? PULSE_LEN : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]   c_pulse_last = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0]   c_ack_last   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [AMT_W_P-1:0] c_den0       = AMT_W_P'(DEN0_P);
    localparam logic [AMT_W_P-1:0] c_den1       = AMT_W_P'(DEN1_P);
    localparam logic [AMT_W_P-1:0] c_den2       = AMT_W_P'(DEN2_P);

    state_e               state_q, state_d;
    logic [AMT_W_P-1:0]   remaining_q, remaining_d;
    logic [AMT_W_P-1:0]   coins_q, coins_d;
    logic [AMT_W_P-1:0]   short_q, short_d;
    logic [2:0]           fault_q, fault_d;
    logic [1:0]           sel_q, sel_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           empty_q;

    logic [1:0]           w_sel;
    logic                 w_sel_valid;
    logic                 w_can_pay;
    logic [AMT_W_P-1:0]   w_sel_den;
    logic                 w_empty_rise;

    change_hopper_select #(
        .AMT_W_P (AMT_W_P),
        .DEN0_P  (DEN0_P),
        .DEN1_P  (DEN1_P),
        .DEN2_P  (DEN2_P)
    ) u_select (
        .remaining    (remaining_q),
        .hopper_empty (hopper_empty),
        .hopper_fault (fault_q),
        .sel          (w_sel),
        .sel_valid    (w_sel_valid)
    );

    assign w_can_pay    = (remaining_q != '0) && w_sel_valid;
    assign w_empty_rise = |((hopper_empty & ~empty_q) & (3'b001 << sel_q));

    always_comb begin
        case (sel_q)
            2'd0:    w_sel_den = c_den0;
            2'd1:    w_sel_den = c_den1;
            default: w_sel_den = c_den2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            coins_q     <= '0;
            short_q     <= '0;
            fault_q     <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            empty_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coins_q     <= coins_d;
            short_q     <= short_d;
            fault_q     <= fault_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            empty_q     <= hopper_empty;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coins_d     = coins_q;
        short_d     = short_q;
        fault_d     = fault_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    remaining_d = req_amount;
                    coins_d     = '0;
                    short_d     = '0;
                    state_d     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                cnt_d = '0;
                if (w_can_pay) begin
                    sel_d   = w_sel;
                    state_d = ST_PULSE;
                end else begin
                    short_d = remaining_q;
                    state_d = ST_DONE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == c_pulse_last) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                // Ack takes priority over an empty edge landing in the same cycle.
                if (disp_ack) begin
                    remaining_d = remaining_q - w_sel_den;
                    if (coins_q != '1) begin
                        coins_d = coins_q + 1'b1;
                    end
                    state_d = ST_SELECT;
                end else if (w_empty_rise) begin
                    state_d = ST_SELECT;
                end else if (cnt_q == c_ack_last) begin
                    fault_d = fault_q | (3'b001 << sel_q);
                    state_d = ST_SELECT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready    = (state_q == ST_IDLE);
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_DONE);
        disp_pulse   = (state_q == ST_PULSE);
        disp_sel     = ((state_q == ST_SELECT) && w_can_pay) ? w_sel : sel_q;
        shortfall    = short_q;
        hopper_fault = fault_q;
        coins_out    = coins_q;
    end

endmodule : change_dispense_ctrl
`default_nettype wire

// File: tb/tb_change_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_change_dispense_ctrl
// Brief   : Self-checking bench for change_dispense_ctrl with a hopper model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_change_dispense_ctrl;
    import vend_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [7:0] req_amount = '0;
    logic       req_ready;
    logic [2:0] hopper_empty = '0;
    logic       disp_ack = 1'b0;
    logic [1:0] disp_sel;
    logic       disp_pulse;
    logic       busy;
    logic       done;
    logic [7:0] shortfall;
    logic [2:0] hopper_fault;
    logic [7:0] coins_out;

    always #5 clk = ~clk;

    change_dispense_ctrl #(
        .AMT_W_P     (8),
        .DEN0_P      (10),
        .DEN1_P      (5),
        .DEN2_P      (1),
        .PULSE_LEN   (2),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_amount   (req_amount),
        .req_ready    (req_ready),
        .hopper_empty (hopper_empty),
        .disp_ack     (disp_ack),
        .disp_sel     (disp_sel),
        .disp_pulse   (disp_pulse),
        .busy         (busy),
        .done         (done),
        .shortfall    (shortfall),
        .hopper_fault (hopper_fault),
        .coins_out    (coins_out)
    );

    int         checks = 0;
    int         fails  = 0;
    int         pulses = 0;
    logic [1:0] exp_q[$];
    logic [2:0] noack = '0;

    typedef struct packed {
        logic [7:0]  amount;
        logic [2:0]  empty;
        logic [3:0]  nsel;
        logic [15:0] sels;   // element i in bits [2i+1:2i]
        logic [7:0]  coins;
        logic [7:0]  shortv;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Hopper model: acks 3 cycles after the strobe falls, unless masked.
    initial begin : hopper_model
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (prev && !disp_pulse && busy && !noack[disp_sel]) begin
                repeat (2) @(negedge clk);
                disp_ack = 1'b1;
                @(negedge clk);
                disp_ack = 1'b0;
                prev = disp_pulse;
            end else begin
                prev = disp_pulse;
            end
        end
    end

    // Scoreboard: each new coin strobe must use the next expected hopper.
    initial begin : monitor
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (disp_pulse && !prev) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_pulse: got sel %0d, expected no pulse", disp_sel);
                end else begin
                    check("disp_sel_seq", disp_sel, exp_q.pop_front());
                end
            end
            prev = disp_pulse;
        end
    end

    task automatic do_req(input logic [7:0] amt);
        int n;
        n = 0;
        @(negedge clk);
        req_amount = amt;
        req_valid  = 1'b1;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_seen", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input logic [7:0] exp_coins, input logic [7:0] exp_short);
        int n;
        int extra;
        bit got;
        n = 0;
        got = 1'b0;
        while (n < 1000) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            n++;
        end
        check("done_seen", got, 1);
        if (got) begin
            check("shortfall", shortfall, exp_short);
            check("coins_out", coins_out, exp_coins);
        end
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("single_done", extra, 0);
        check("seq_complete", exp_q.size(), 0);
        check("idle_after", busy, 0);
    endtask

    vec_t vecs[3];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int p0;
        int n;
        vecs[0] = '{amount: 8'd27, empty: 3'b000, nsel: 4'd5,
                    sels: {6'd0, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0}, coins: 8'd5, shortv: 8'd0};
        vecs[1] = '{amount: 8'd15, empty: 3'b010, nsel: 4'd6,
                    sels: {4'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0}, coins: 8'd6, shortv: 8'd0};
        vecs[2] = '{amount: 8'd8, empty: 3'b100, nsel: 4'd1,
                    sels: {14'd0, 2'd1}, coins: 8'd1, shortv: 8'd3};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pulse", disp_pulse, 0);
        check("rst_sel", disp_sel, 0);
        check("rst_short", shortfall, 0);
        check("rst_fault", hopper_fault, 0);
        check("rst_coins", coins_out, 0);

        for (int i = 0; i < 3; i++) begin
            hopper_empty = vecs[i].empty;
            for (int k = 0; k < int'(vecs[i].nsel); k++) begin
                exp_q.push_back(vecs[i].sels[2*k +: 2]);
            end
            do_req(vecs[i].amount);
            wait_done(vecs[i].coins, vecs[i].shortv);
        end
        hopper_empty = 3'b000;

        // Zero request: SELECT then DONE, no strobe.
        p0 = pulses;
        do_req(8'd0);
        @(negedge clk);
        check("zero_done_cycle1", done, 0);
        @(negedge clk);
        check("zero_done_cycle2", done, 1);
        check("zero_short", shortfall, 0);
        repeat (3) @(negedge clk);
        check("zero_no_pulse", pulses - p0, 0);

        // Hopper 0 never acks: timeout marks it faulty, fives pay instead.
        noack = 3'b001;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        do_req(8'd10);
        wait_done(8'd2, 8'd0);
        check("fault_set", hopper_fault, 3'b001);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        do_req(8'd10);
        wait_done(8'd2, 8'd0);
        check("fault_sticky", hopper_fault, 3'b001);

        // Reset during a coin strobe abandons the request.
        noack = 3'b000;
        exp_q.push_back(2'd1);
        do_req(8'd20);
        n = 0;
        while (!disp_pulse && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pulse_before_rst", disp_pulse, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pulse", disp_pulse, 0);
        check("mid_rst_fault", hopper_fault, 0);
        check("mid_rst_coins", coins_out, 0);
        rst = 1'b0;
        exp_q.delete();
        repeat (6) @(negedge clk);
        exp_q.push_back(2'd1);
        do_req(8'd5);
        wait_done(8'd1, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_change_dispense_ctrl
`default_nettype wire

// File: doc/change_dispense_ctrl.md
Name: change_dispense_ctrl

Overview:
- Sequences the vending machine's change payout after a sale: accepts a change amount from the vending FSM and drives up to three coin hoppers (10, 5, 1 units), one coin at a time, using a largest-denomination-first policy.
- Handles the pulse/acknowledge handshake with each hopper motor, skips empty or unresponsive hoppers, and reports any unpaid shortfall.
- Sits between the vending FSM change output and the hopper driver board.

Parameters:
- AMT_W, 8: width of the amount and shortfall fields, in units.
- DEN0, 10: value of hopper 0 (largest denomination).
- DEN1, 5: value of hopper 1.
- DEN2, 1: value of hopper 2 (smallest denomination).
- PULSE_LEN, 2: number of cycles disp_pulse is held high per coin.
- ACK_TIMEOUT, 16: cycles allowed in WAIT_ACK before the hopper is declared faulty.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  change request present.
- req_amount  in  AMT_W  change to pay, in units.
- req_ready  out  1  high only in IDLE; a request is accepted on req_valid && req_ready.
- hopper_empty  in  3  per-hopper empty flag; bit i belongs to hopper i.
- disp_ack  in  1  the selected hopper has ejected one coin (single-cycle pulse).
- disp_sel  out  2  hopper index 0..2; held stable from SELECT through WAIT_ACK.
- disp_pulse  out  1  motor strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of every accepted request.
- shortfall  out  AMT_W  amount left unpaid; valid while done=1 and held until the next acceptance.
- hopper_fault  out  3  sticky per-hopper timeout flags; cleared only by rst.
- coins_out  out  AMT_W  coins ejected for the current request; cleared on acceptance.

Behaviour:
- Reset (rst sampled high at a rising edge) values: state=IDLE, req_ready=1, busy=0, done=0, disp_pulse=0, disp_sel=0, shortfall=0, hopper_fault=0, coins_out=0, internal remaining=0. rst overrides any in-progress request; a coin being pulsed is abandoned without further accounting.
- States: IDLE, SELECT, PULSE, WAIT_ACK, DONE.
- IDLE:
  - On acceptance, latch req_amount into remaining, clear coins_out and shortfall, and go to SELECT on the next cycle.
- SELECT (exactly 1 cycle):
  - If remaining=0, go to DONE.
  - Otherwise pick the lowest index i such that DENi <= remaining, hopper_empty[i]=0 and hopper_fault[i]=0. Drive disp_sel=i and go to PULSE.
  - If no hopper qualifies, go to DONE.
- PULSE:
  - disp_pulse=1 for exactly PULSE_LEN consecutive cycles, then go to WAIT_ACK.
  - disp_ack is ignored in this state.
- WAIT_ACK:
  - On disp_ack=1: remaining -= DEN[disp_sel], coins_out += 1, go to SELECT.
  - On a hopper_empty rising edge for the selected hopper with no ack, go to SELECT with no decrement.
  - If disp_ack and the empty edge arrive in the same cycle, the ack wins (count the coin).
  - If ACK_TIMEOUT cycles pass without ack, set hopper_fault[disp_sel] and go to SELECT.
  - The timeout counter clears on entry to WAIT_ACK.
- DONE (exactly 1 cycle):
  - done=1 and shortfall=remaining, then go to IDLE.
- Arithmetic:
  - remaining never underflows, because selection guarantees DENi <= remaining.
  - coins_out saturates at all-ones.
- A zero-amount request goes IDLE -> SELECT -> DONE, with done asserted 2 cycles after acceptance and shortfall=0.
- Latency per coin is 1 (SELECT) + PULSE_LEN + ack delay cycles.
- req_valid is ignored while busy; the requester must hold it until req_ready is seen.

Decomposition:
- Shared package vend_pkg holds:
  - the state enum;
  - the denomination constants DEN0..DEN2 and the hopper count (3);
  - the AMT_W default.
- One sub-module: change_hopper_select, a combinational priority picker.
  - Inputs: remaining, hopper_empty, hopper_fault.
  - Outputs: sel[1:0], sel_valid.
- Everything else (FSM, pulse and timeout counters, accounting) lives in change_dispense_ctrl.

Test Plan:
- Reset, then request 27 with all hoppers full and ack 3 cycles after each pulse falls:
  - disp_sel sequence must be 0,0,1,2,2;
  - coins_out=5, shortfall=0, exactly one done pulse.
- Request 15 with hopper_empty=3'b010:
  - disp_sel sequence must be 0,2,2,2,2,2;
  - coins_out=6, shortfall=0.
- Request 8 with hopper_empty=3'b100:
  - hopper 1 pays once, then no hopper qualifies;
  - done with shortfall=3, coins_out=1.
- Request 10 with hopper 0 never acking:
  - after ACK_TIMEOUT=16 cycles in WAIT_ACK, hopper_fault=3'b001;
  - then two 5-unit coins, shortfall=0;
  - a second request of 10 must skip hopper 0 immediately.
- Request 0:
  - done exactly 2 cycles after acceptance, shortfall=0, disp_pulse never asserted.
- Assert rst during PULSE of a request of 20:
  - next cycle state=IDLE, disp_pulse=0, req_ready=1, hopper_fault=0;
  - a new request of 5 then completes normally.
